axi4_mem_master: RTL



---
 rtl/axi4_mem_master_if.sv | 37 +++
 rtl/axi4_mem_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_master_if.sv
// AXI4 read/write channel bundle between axi4_mem_master and the mem controller.
interface axi4_mem_master_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] axi_araddr;
   logic                  axi_arvalid;
   logic                  axi_arready;
   logic [DATA_WIDTH-1:0] axi_rdata;
   logic                  axi_rlast;
   logic                  axi_rvalid;
   logic                  axi_rready;
   logic [ADDR_WIDTH-1:0] axi_awaddr;
   logic                  axi_awvalid;
   logic                  axi_awready;
   logic [DATA_WIDTH-1:0] axi_wdata;
   logic                  axi_wlast;
   logic                  axi_wvalid;
   logic                  axi_wready;
   logic                  axi_bresp;
   logic                  axi_bvalid;
   logic                  axi_bready;

   modport master (
      output axi_araddr, axi_arvalid, axi_rready,
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wlast, axi_wvalid, axi_bready,
      input  axi_arready, axi_rdata, axi_rlast, axi_rvalid,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid
   );

   modport slave (
      input  axi_araddr, axi_arvalid, axi_rready,
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wlast, axi_wvalid, axi_bready,
      output axi_arready, axi_rdata, axi_rlast, axi_rvalid,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid
   );
endinterface

// File: rtl/axi4_mem_master.sv
// axi4_mem_master: single-outstanding AXI4 master turning each core request into one
// single-beat AXI read (AR, R) or write (AW+W, B) and returning one response pulse.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort any channel wait lasting
// TIMEOUT_CYCLES cycles with an error response (drops valids without handshake).
module axi4_mem_master #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  axi_clk,
   input  logic                  axi_resetn,
   input  logic                  core_req_valid,
   output logic                  core_req_ready,
   input  logic                  core_req_we,
   input  logic [ADDR_WIDTH-1:0] core_req_addr,
   input  logic [DATA_WIDTH-1:0] core_req_wdata,
   output logic                  core_resp_valid,
   output logic [DATA_WIDTH-1:0] core_resp_rdata,
   output logic                  core_resp_err,
   axi4_mem_master_if.master     axi
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR_DATA,
      WR_RESP
   } state_t;

   state_t state;

   logic ar_hs_c;
   logic r_hs_c;
   logic wr_done_c;
   logic b_hs_c;
   logic tmo_hit_c;
   logic unused_c;

   assign ar_hs_c   = axi.axi_arvalid & axi.axi_arready;
   assign r_hs_c    = axi.axi_rvalid & axi.axi_rready;
   // AW and W are each done once their valid is low or handshaking this edge
   assign wr_done_c = (~axi.axi_awvalid | axi.axi_awready) & (~axi.axi_wvalid | axi.axi_wready);
   assign b_hs_c    = axi.axi_bvalid & axi.axi_bready;

   // Single-beat transfers only, so rlast carries no information
   assign unused_c  = axi.axi_rlast;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             leave_c;

   assign leave_c = ((state == RD_ADDR)      && ar_hs_c)   ||
                    ((state == RD_DATA)      && r_hs_c)    ||
                    ((state == WR_ADDR_DATA) && wr_done_c) ||
                    ((state == WR_RESP)      && b_hs_c);

   // Watchdog: cleared on every state entry, counts cycles spent waiting on a channel
   always_ff @(posedge axi_clk) begin
      if (!axi_resetn || (state == IDLE) || leave_c) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_hit_c = (state != IDLE) && !leave_c &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_tmo_c;

   assign unused_tmo_c = 32'(TIMEOUT_CYCLES);
   assign tmo_hit_c    = 1'b0;
`endif

   // Transaction FSM; every core and AXI output is a register updated here
   always_ff @(posedge axi_clk) begin
      if (!axi_resetn) begin
         state           <= IDLE;
         core_req_ready  <= 1'b0;
         core_resp_valid <= 1'b0;
         core_resp_rdata <= '0;
         core_resp_err   <= 1'b0;
         axi.axi_araddr  <= '0;
         axi.axi_arvalid <= 1'b0;
         axi.axi_rready  <= 1'b0;
         axi.axi_awaddr  <= '0;
         axi.axi_awvalid <= 1'b0;
         axi.axi_wdata   <= '0;
         axi.axi_wlast   <= 1'b0;
         axi.axi_wvalid  <= 1'b0;
         axi.axi_bready  <= 1'b0;
      end else begin
         core_resp_valid <= 1'b0;
         if (tmo_hit_c) begin
            axi.axi_arvalid <= 1'b0;
            axi.axi_rready  <= 1'b0;
            axi.axi_awvalid <= 1'b0;
            axi.axi_wvalid  <= 1'b0;
            axi.axi_wlast   <= 1'b0;
            axi.axi_bready  <= 1'b0;
            core_resp_valid <= 1'b1;
            core_resp_err   <= 1'b1;
            core_resp_rdata <= '0;
            core_req_ready  <= 1'b1;
            state           <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (core_req_valid && core_req_ready) begin
                     core_req_ready <= 1'b0;
                     if (core_req_we) begin
                        axi.axi_awaddr  <= core_req_addr;
                        axi.axi_wdata   <= core_req_wdata;
                        axi.axi_awvalid <= 1'b1;
                        axi.axi_wvalid  <= 1'b1;
                        axi.axi_wlast   <= 1'b1;
                        state           <= WR_ADDR_DATA;
                     end else begin
                        axi.axi_araddr  <= core_req_addr;
                        axi.axi_arvalid <= 1'b1;
                        state           <= RD_ADDR;
                     end
                  end else begin
                     core_req_ready <= 1'b1;
                  end
               end
               RD_ADDR: begin
                  if (ar_hs_c) begin
                     axi.axi_arvalid <= 1'b0;
                     axi.axi_rready  <= 1'b1;
                     state           <= RD_DATA;
                  end
               end
               RD_DATA: begin
                  if (r_hs_c) begin
                     axi.axi_rready  <= 1'b0;
                     core_resp_rdata <= axi.axi_rdata;
                     core_resp_valid <= 1'b1;
                     core_resp_err   <= 1'b0;
                     core_req_ready  <= 1'b1;
                     state           <= IDLE;
                  end
               end
               WR_ADDR_DATA: begin
                  if (axi.axi_awvalid && axi.axi_awready) begin
                     axi.axi_awvalid <= 1'b0;
                  end
                  if (axi.axi_wvalid && axi.axi_wready) begin
                     axi.axi_wvalid <= 1'b0;
                     axi.axi_wlast  <= 1'b0;
                  end
                  if (wr_done_c) begin
                     axi.axi_bready <= 1'b1;
                     state          <= WR_RESP;
                  end
               end
               WR_RESP: begin
                  if (b_hs_c) begin
                     axi.axi_bready  <= 1'b0;
                     core_resp_valid <= 1'b1;
                     core_resp_err   <= axi.axi_bresp;
                     core_resp_rdata <= '0;
                     core_req_ready  <= 1'b1;
                     state           <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
